yl3_frame_scheduler: RTL and testbench
======================================

Name: yl3_frame_scheduler

Overview:
Shares one YL-3 eight-digit display driver among NUM_REQ requesters. Each requester deposits a 64-bit, 8-character frame into its own slot through a req/ack handshake. The scheduler continuously re-issues the active slot's frame to the driver through the driver's ready/load handshake, which keeps the display refreshed. It rotates ownership round-robin after DWELL_FRAMES completed refreshes and sits directly above the YL-3 driver in the display path.

Parameters:
NUM_REQ, 2, number of requester slots; legal range 2..4.
DWELL_FRAMES, 200, completed driver refreshes before rotating to the next valid slot; legal range 1..65535.
BLANK_FRAME, 64'h2020_2020_2020_2020, frame sent when no slot is valid (eight spaces, all digits dark).

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
req  in  NUM_REQ  per-slot write request; level, held until ack
rel  in  NUM_REQ  per-slot release; one-cycle pulse clears the slot's valid bit
frame_in  in  64*NUM_REQ  slot i frame at [64*i+63:64*i]; char0 (leftmost digit) in the MSB byte
ack  out  NUM_REQ  one-cycle pulse; frame captured into slot i
active_idx  out  2  slot currently owning the display
active_vld  out  1  1 when active_idx refers to a valid slot; 0 when BLANK_FRAME is shown
frame_done  out  1  one-cycle pulse per completed driver refresh
drv_load  out  1  to driver load
drv_data  out  64  to driver data
drv_ready  in  1  from driver ready

Behaviour:
- Reset is synchronous and active-low on clk (rst_n).
- Reset values:
  - all slots invalid; ack = 0; active_idx = 0; active_vld = 0; frame_done = 0
  - drv_load = 0; drv_data = BLANK_FRAME; dwell counter = 0; state = S_WAIT
- Reset mid-operation abandons any transfer at once. The driver shares rst_n, so no recovery sequence is needed.
- Slot capture:
  - When req[i]=1 and ack[i]=0, slot[i] <= frame_in slice, valid[i] <= 1, and ack[i] pulses the next cycle.
  - All slots may capture in the same cycle.
  - A requester that holds req after ack gets a recapture every other cycle; this is legal and idempotent.
- rel[i] clears valid[i]. If req[i] and rel[i] are both asserted in the same cycle, capture wins and valid stays 1.
- A capture into the active slot takes effect at the next S_LOAD entry. drv_data never changes while drv_load=1.
- FSM:
  - S_WAIT: wait for drv_ready=1. Then select the source per the rotation rules, register it into drv_data, and go to S_LOAD.
  - S_LOAD: drv_load=1 with drv_data held. The driver needs at least 2 cycles of load, because it copies first and accepts on the compare. Stay until drv_ready is sampled 0, then drv_load <= 0 and go to S_BUSY.
  - S_BUSY: wait for drv_ready=1. Then pulse frame_done, increment the dwell counter, and go to S_WAIT in the same cycle.
- Rotation, evaluated at S_WAIT exit:
  - Active slot invalid: search (active_idx+1) mod NUM_REQ upward for a valid slot. If one is found, switch and clear the dwell counter; if none, send BLANK_FRAME with active_vld=0.
  - Active slot valid and dwell counter >= DWELL_FRAMES: search the next valid slot the same way and clear the counter. If the only valid slot is the current one, keep it and clear the counter.
  - Otherwise keep the current slot.
- Dwell counter is 16 bits and saturates; it never wraps.
- Slot release during S_LOAD/S_BUSY does not abort the transfer. The frame completes and the switch happens at the next S_WAIT.
- Inputs are not registered beyond the slot capture. Worst-case latency from ack to display start is one driver refresh in progress plus one S_WAIT cycle.

Optional Feature:
YL3_SCHED_PRIORITY_EN
- Defined: slot 0 is a priority owner. Whenever valid[0]=1 at S_WAIT exit, slot 0 is selected regardless of dwell, and the dwell counter is held at 0. When slot 0 is released, round-robin resumes from slot 1.
- Undefined: pure round-robin as above, and slot 0 has no special treatment.

Test Plan:
- Reset, no requests, driver model with ready low for 40 cycles per refresh -> drv_data = 64'h2020202020202020 and active_vld=0 every load; frame_done pulses once per refresh; ack stays 0.
- req[0] with frame "12345678", DWELL_FRAMES=3 -> ack[0] pulses one cycle after req; the next load carries 64'h3132333435363738 and active_idx=0 repeats indefinitely with no rotation to invalid slot 1.
- Slots 0 "AAAAAAAA" and 1 "bbbbbbbb" both valid, DWELL_FRAMES=3 -> load sequence 0,0,0,1,1,1,0,...; drv_data stable on every cycle drv_load=1.
- rel[1] while slot 1 is mid-S_BUSY -> the current refresh completes with slot 1 data; the next load uses slot 0 and the dwell counter is reset.
- Same-cycle req[0] and rel[0] -> valid[0] stays 1 and the new frame appears at the next load. A new req[0] while slot 0 is in S_LOAD -> drv_data unchanged until the next S_WAIT.
- YL3_SCHED_PRIORITY_EN defined, slots 0 and 1 valid, DWELL_FRAMES=1 -> slot 0 on every load. rel[0] -> next load uses slot 1.

Source files
------------

// File: rtl/yl3_frame_scheduler.sv
// Round-robin owner of a YL-3 eight-digit display driver; keeps the driver refreshed from the active slot.
// Optional build macro YL3_SCHED_PRIORITY_EN makes slot 0 a priority owner whenever it holds a valid frame.
module yl3_frame_scheduler #(
    parameter int          NUM_REQ      = 2,
    parameter int          DWELL_FRAMES = 200,
    parameter logic [63:0] BLANK_FRAME  = 64'h2020_2020_2020_2020
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     rel,
    input  logic [64*NUM_REQ-1:0]  frame_in,
    output logic [NUM_REQ-1:0]     ack,
    output logic [1:0]             active_idx,
    output logic                   active_vld,
    output logic                   frame_done,
    output logic                   drv_load,
    output logic [63:0]            drv_data,
    input  logic                   drv_ready
);

    typedef enum logic [1:0] {S_WAIT, S_LOAD, S_BUSY} state_t;

    state_t              state;
    logic [NUM_REQ-1:0]  valid;
    logic [63:0]         slot_data [NUM_REQ];
    logic [15:0]         dwell;
    logic [NUM_REQ-1:0]  cap;

    logic                act_valid;
    logic                nxt_found;
    logic [1:0]          nxt_idx;
    logic                sel_vld;
    logic [1:0]          sel_idx;
    logic                dwell_clr;
    logic [63:0]         sel_data;
    logic [15:0]         dwell_next;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // A held req recaptures only while ack is low, giving one capture every other cycle.
    assign cap = req & ~ack;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack   <= '0;
            valid <= '0;
        end else begin
            ack   <= cap;
            valid <= cap | (valid & ~rel);
        end
    end

    always_ff @(posedge clk) begin
        for (int j = 0; j < NUM_REQ; j++) begin
            if (cap[j]) slot_data[j] <= frame_in[64*j +: 64];
        end
    end

    always_comb begin
        act_valid = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (active_idx == 2'(j)) act_valid = valid[j];
        end
    end

    // Scan from the farthest candidate down so the nearest valid slot after active_idx wins.
    always_comb begin
        nxt_found = 1'b0;
        nxt_idx   = active_idx;
        for (int k = NUM_REQ - 1; k >= 1; k--) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (valid[j] && (2'(j) == 2'((int'(active_idx) + k) % NUM_REQ))) begin
                    nxt_found = 1'b1;
                    nxt_idx   = 2'(j);
                end
            end
        end
    end

    always_comb begin
        sel_idx   = active_idx;
        sel_vld   = 1'b0;
        dwell_clr = 1'b0;
        if (act_valid) begin
            sel_vld = 1'b1;
            if (dwell >= 16'(DWELL_FRAMES)) begin
                dwell_clr = 1'b1;
                if (nxt_found) sel_idx = nxt_idx;
            end
        end else if (nxt_found) begin
            sel_idx   = nxt_idx;
            sel_vld   = 1'b1;
            dwell_clr = 1'b1;
        end
`ifdef YL3_SCHED_PRIORITY_EN
        if (valid[0]) begin
            sel_idx   = 2'd0;
            sel_vld   = 1'b1;
            dwell_clr = 1'b1;
        end
`endif
    end

    always_comb begin
        sel_data = BLANK_FRAME;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (sel_vld && (sel_idx == 2'(j))) sel_data = slot_data[j];
        end
    end

`ifdef YL3_SCHED_PRIORITY_EN
    // While slot 0 owns the display the dwell counter stays pinned at zero.
    assign dwell_next = (active_vld && active_idx == 2'd0) ? 16'd0 : sat_inc16(dwell);
`else
    assign dwell_next = sat_inc16(dwell);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_WAIT;
            drv_load   <= 1'b0;
            drv_data   <= BLANK_FRAME;
            active_idx <= 2'd0;
            active_vld <= 1'b0;
            frame_done <= 1'b0;
            dwell      <= 16'd0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_WAIT: begin
                    if (drv_ready) begin
                        drv_data   <= sel_data;
                        active_idx <= sel_idx;
                        active_vld <= sel_vld;
                        if (dwell_clr) dwell <= 16'd0;
                        drv_load   <= 1'b1;
                        state      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // The driver drops ready only after it has copied and accepted the frame.
                    if (!drv_ready) begin
                        drv_load <= 1'b0;
                        state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (drv_ready) begin
                        frame_done <= 1'b1;
                        dwell      <= dwell_next;
                        state      <= S_WAIT;
                    end
                end
                default: state <= S_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_yl3_frame_scheduler.sv
// Directed bench for yl3_frame_scheduler with a behavioural YL-3 driver handshake model.
`timescale 1ns/1ps
module tb_yl3_frame_scheduler;

`ifdef YL3_SCHED_PRIORITY_EN
    localparam int DW = 1;
`else
    localparam int DW = 3;
`endif
    localparam logic [63:0] BLANK = 64'h2020_2020_2020_2020;
    localparam logic [63:0] F_NUM = 64'h3132_3334_3536_3738;
    localparam logic [63:0] F_A   = 64'h4141_4141_4141_4141;
    localparam logic [63:0] F_B   = 64'h6262_6262_6262_6262;
    localparam logic [63:0] F_C   = 64'h6363_6363_6363_6363;
    localparam logic [63:0] F_Z   = 64'h5A5A_5A5A_5A5A_5A5A;
    localparam logic [63:0] F_9   = 64'h3939_3939_3939_3939;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req, rel, ack;
    logic [127:0] frame_in;
    logic [1:0]   active_idx;
    logic         active_vld, frame_done, drv_load, drv_ready;
    logic [63:0]  drv_data;

    int n_chk = 0;
    int n_pass = 0;

    logic        drv_en = 1'b0;
    int          busy_len = 4;
    int          load_cnt, busy_cnt;
    int          fd_cnt = 0;
    logic        unstable = 1'b0;
    logic        ack_any = 1'b0;
    logic [63:0] ref_data;
    logic [63:0] ld_data[$];
    logic [1:0]  ld_idx[$];
    logic        ld_vld[$];

    yl3_frame_scheduler #(.NUM_REQ(2), .DWELL_FRAMES(DW), .BLANK_FRAME(BLANK)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .rel(rel), .frame_in(frame_in),
        .ack(ack), .active_idx(active_idx), .active_vld(active_vld),
        .frame_done(frame_done), .drv_load(drv_load), .drv_data(drv_data),
        .drv_ready(drv_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Driver: holds ready through two load cycles, then stays busy for busy_len cycles.
    initial begin
        drv_ready = 1'b0;
        load_cnt  = 0;
        busy_cnt  = 0;
        forever begin
            @(negedge clk);
            if (frame_done) fd_cnt++;
            if (|ack) ack_any = 1'b1;
            if (!drv_en) begin
                drv_ready = 1'b0;
                load_cnt  = 0;
                busy_cnt  = 0;
            end else if (drv_ready) begin
                if (drv_load) begin
                    if (load_cnt == 0) begin
                        ld_data.push_back(drv_data);
                        ld_idx.push_back(active_idx);
                        ld_vld.push_back(active_vld);
                        ref_data = drv_data;
                    end else if (drv_data !== ref_data) begin
                        unstable = 1'b1;
                    end
                    load_cnt++;
                    if (load_cnt >= 2) begin
                        drv_ready = 1'b0;
                        busy_cnt  = busy_len;
                        load_cnt  = 0;
                    end
                end
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) drv_ready = 1'b1;
            end else begin
                drv_ready = 1'b1;
            end
        end
    end

    task automatic do_reset(input string tag);
        @(negedge clk);
        drv_en = 1'b0; req = '0; rel = '0; rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ld_data.delete(); ld_idx.delete(); ld_vld.delete();
        fd_cnt = 0; unstable = 1'b0; ack_any = 1'b0;
        @(negedge clk);
        chk({tag, "_rst_load"}, 64'(drv_load), 64'd0);
        chk({tag, "_rst_data"}, drv_data, BLANK);
        chk({tag, "_rst_vld"}, 64'(active_vld), 64'd0);
        chk({tag, "_rst_idx"}, 64'(active_idx), 64'd0);
        chk({tag, "_rst_ack"}, 64'(ack), 64'd0);
    endtask

    task automatic capture(input string tag, input logic [1:0] mask,
                           input logic [63:0] f0, input logic [63:0] f1);
        @(negedge clk);
        frame_in = {f1, f0};
        req = mask;
        @(negedge clk);
        chk({tag, "_ack"}, 64'(ack), 64'(mask));
        req = '0;
        @(negedge clk);
        chk({tag, "_ack_off"}, 64'(ack), 64'd0);
    endtask

    task automatic wait_loads(input string tag, input int n);
        int c = 0;
        while (ld_data.size() < n && c < 2000) begin
            @(posedge clk);
            c++;
        end
        if (ld_data.size() < n) chk({tag, "_timeout"}, 64'(ld_data.size()), 64'(n));
    endtask

    task automatic wait_lvl(input string tag, input logic lvl);
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (drv_load !== lvl && c < 200);
        if (drv_load !== lvl) chk({tag, "_lvl_timeout"}, 64'(drv_load), 64'(lvl));
    endtask

    task automatic chk_load(input string tag, input int i, input logic [1:0] idx,
                            input logic [63:0] data, input logic vld);
        chk($sformatf("%s_idx%0d", tag, i), 64'(ld_idx[i]), 64'(idx));
        chk($sformatf("%s_data%0d", tag, i), ld_data[i], data);
        chk($sformatf("%s_vld%0d", tag, i), 64'(ld_vld[i]), 64'(vld));
    endtask

    initial begin
        rst_n = 1'b0; req = '0; rel = '0; frame_in = '0;

`ifndef YL3_SCHED_PRIORITY_EN
        // Idle display: blank frames only, long driver refresh.
        do_reset("idle");
        busy_len = 40;
        drv_en = 1'b1;
        wait_loads("idle", 3);
        for (int i = 0; i < 3; i++) chk_load("idle", i, 2'd0, BLANK, 1'b0);
        chk("idle_frame_done", 64'(fd_cnt), 64'd2);
        chk("idle_no_ack", 64'(ack_any), 64'd0);

        // Single valid slot never rotates to the empty one.
        do_reset("one");
        busy_len = 4;
        capture("one", 2'b01, F_NUM, 64'd0);
        drv_en = 1'b1;
        wait_loads("one", 6);
        for (int i = 0; i < 6; i++) chk_load("one", i, 2'd0, F_NUM, 1'b1);

        // Two slots alternate every DW refreshes.
        do_reset("rr");
        capture("rr", 2'b11, F_A, F_B);
        drv_en = 1'b1;
        wait_loads("rr", 7);
        begin
            logic [1:0] exp_seq [7] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
            for (int i = 0; i < 7; i++)
                chk_load("rr", i, exp_seq[i], (exp_seq[i] == 2'd1) ? F_B : F_A, 1'b1);
        end
        chk("rr_stable", 64'(unstable), 64'd0);

        // Release of the active slot during its refresh.
        do_reset("relb");
        capture("relb", 2'b11, F_A, F_B);
        drv_en = 1'b1;
        wait_loads("relb", 4);
        chk_load("relb", 3, 2'd1, F_B, 1'b1);
        wait_lvl("relb", 1'b0);
        rel = 2'b10;
        @(negedge clk);
        rel = '0;
        wait_loads("relb", 5);
        chk_load("relb", 4, 2'd0, F_A, 1'b1);
        chk("relb_frame_done", 64'(fd_cnt), 64'd4);
        capture("relb_re", 2'b10, F_A, F_C);
        wait_loads("relb", 8);
        chk_load("relb", 5, 2'd0, F_A, 1'b1);
        chk_load("relb", 6, 2'd0, F_A, 1'b1);
        chk_load("relb", 7, 2'd1, F_C, 1'b1);

        // Same-cycle req and rel, then a recapture while loading.
        do_reset("rq");
        capture("rq", 2'b01, F_A, 64'd0);
        drv_en = 1'b1;
        wait_loads("rq", 1);
        wait_lvl("rq", 1'b0);
        frame_in = {64'd0, F_Z};
        req = 2'b01; rel = 2'b01;
        @(negedge clk);
        chk("rq_ack", 64'(ack), 64'd1);
        req = '0; rel = '0;
        wait_lvl("rq", 1'b1);
        frame_in = {64'd0, F_9};
        req = 2'b01;
        @(negedge clk);
        chk("rq_ack2", 64'(ack), 64'd1);
        chk("rq_hold_load", 64'(drv_load), 64'd1);
        chk("rq_hold_data", drv_data, F_Z);
        req = '0;
        wait_loads("rq", 3);
        chk_load("rq", 1, 2'd0, F_Z, 1'b1);
        chk_load("rq", 2, 2'd0, F_9, 1'b1);
        chk("rq_stable", 64'(unstable), 64'd0);
`else
        // Slot 0 keeps ownership regardless of dwell until released.
        do_reset("pri");
        busy_len = 4;
        capture("pri", 2'b11, F_A, F_B);
        drv_en = 1'b1;
        wait_loads("pri", 4);
        for (int i = 0; i < 4; i++) chk_load("pri", i, 2'd0, F_A, 1'b1);
        wait_lvl("pri", 1'b0);
        rel = 2'b01;
        @(negedge clk);
        rel = '0;
        wait_loads("pri", 6);
        chk_load("pri", 4, 2'd1, F_B, 1'b1);
        chk_load("pri", 5, 2'd1, F_B, 1'b1);
        chk("pri_stable", 64'(unstable), 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
